reorder_buffer: RTL

Circular reorder buffer for the out-of-order core. It sits between decode/rename and the map table/register file. Decode allocates one entry per instruction and writes the returned tag into the map table. The CDB marks entries complete, and the oldest completed entry retires in program order. At commit the block drives the map table's commit-read address and the one-hot per-register reset vector that clears stale mappings.

---
 rtl/reorder_buffer_if.sv | 58 +++++
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Decode / CDB / operand-read / commit bus between the core and the reorder buffer.
interface reorder_buffer_if #(
  parameter int unsigned ROBsize      = 8,
  parameter int unsigned dataWidth    = 32,
  parameter int unsigned mapValueSize = $clog2(ROBsize + 1)
);

  // allocation from decode/rename
  logic                    alloc_valid_i;
  logic [4:0]              alloc_destReg_i;
  logic                    alloc_regWrite_i;
  logic                    alloc_ready_o;
  logic [mapValueSize-1:0] alloc_tag_o;

  // common data bus
  logic                    cdb_valid_i;
  logic [mapValueSize-1:0] cdb_tag_i;
  logic [dataWidth-1:0]    cdb_value_i;

  // operand read ports
  logic [mapValueSize-1:0] readTag1_i;
  logic [mapValueSize-1:0] readTag2_i;
  logic                    readReady1_o;
  logic                    readReady2_o;
  logic [dataWidth-1:0]    readValue1_o;
  logic [dataWidth-1:0]    readValue2_o;

  // in-order commit toward the map table / register file
  logic                    commitValid_o;
  logic                    commitRegWrite_o;
  logic [4:0]              commitDestReg_o;
  logic [dataWidth-1:0]    commitValue_o;
  logic [mapValueSize-1:0] commitMapData_i;
  logic [31:0]             resets_o;

  modport master (
    output alloc_valid_i, alloc_destReg_i, alloc_regWrite_i,
    input  alloc_ready_o, alloc_tag_o,
    output cdb_valid_i, cdb_tag_i, cdb_value_i,
    output readTag1_i, readTag2_i,
    input  readReady1_o, readReady2_o, readValue1_o, readValue2_o,
    input  commitValid_o, commitRegWrite_o, commitDestReg_o, commitValue_o,
    output commitMapData_i,
    input  resets_o
  );

  modport slave (
    input  alloc_valid_i, alloc_destReg_i, alloc_regWrite_i,
    output alloc_ready_o, alloc_tag_o,
    input  cdb_valid_i, cdb_tag_i, cdb_value_i,
    input  readTag1_i, readTag2_i,
    output readReady1_o, readReady2_o, readValue1_o, readValue2_o,
    output commitValid_o, commitRegWrite_o, commitDestReg_o, commitValue_o,
    input  commitMapData_i,
    output resets_o
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, CDB completion, in-order retire.
// Entry i carries tag i+1; tag 0 means the value lives in the register file.
module reorder_buffer #(
  parameter int unsigned ROBsize   = 8,
  parameter int unsigned dataWidth = 32
) (
  input  logic             clk,
  input  logic             reset,
  reorder_buffer_if.slave  rob
);

  localparam int unsigned MW = $clog2(ROBsize + 1);
  localparam int unsigned PW = (ROBsize > 1) ? $clog2(ROBsize) : 1;
  localparam int unsigned DW = dataWidth;

  localparam logic [MW-1:0] TagOne  = MW'(1);
  localparam logic [MW-1:0] TagMax  = MW'(ROBsize);
  localparam logic [PW-1:0] PtrLast = PW'(ROBsize - 1);
  localparam logic [4:0]    RegZeroAlias = 5'd31;

  // control state
  logic [PW-1:0]      head_q;
  logic [PW-1:0]      tail_q;
  logic [MW-1:0]      count_q;
  logic [ROBsize-1:0] valid_q;
  logic [ROBsize-1:0] done_q;

  // payload state (no reset needed: guarded by valid/done)
  logic [ROBsize-1:0] regwrite_q;
  logic [4:0]         dest_q  [ROBsize];
  logic [DW-1:0]      value_q [ROBsize];

  logic          do_alloc;
  logic          do_commit;
  logic          cdb_hit;
  logic [PW-1:0] cdb_idx;
  logic [MW-1:0] head_tag;
  logic [PW-1:0] head_nxt;
  logic [PW-1:0] tail_nxt;

  // pointer / handshake decode from registered state
  assign rob.alloc_ready_o = (count_q < TagMax);
  assign rob.alloc_tag_o   = MW'(tail_q) + TagOne;
  assign head_tag          = MW'(head_q) + TagOne;
  assign head_nxt          = (head_q == PtrLast) ? '0 : head_q + PW'(1);
  assign tail_nxt          = (tail_q == PtrLast) ? '0 : tail_q + PW'(1);

  assign do_alloc  = rob.alloc_valid_i & rob.alloc_ready_o;
  assign do_commit = rob.commitValid_o;

  // a broadcast only lands on a live entry with an in-range tag
  assign cdb_idx = PW'(rob.cdb_tag_i - TagOne);
  assign cdb_hit = rob.cdb_valid_i && (rob.cdb_tag_i != '0) &&
                   (rob.cdb_tag_i <= TagMax) && valid_q[cdb_idx];

  // head entry view for the commit port
  assign rob.commitValid_o    = (count_q != '0) & done_q[head_q];
  assign rob.commitRegWrite_o = rob.commitValid_o & regwrite_q[head_q];
  assign rob.commitDestReg_o  = dest_q[head_q];
  assign rob.commitValue_o    = value_q[head_q];

  // clear the map-table entry only if it still points at the retiring tag
  always_comb begin
    rob.resets_o = '0;
    if (rob.commitRegWrite_o && (rob.commitMapData_i == head_tag) &&
        (rob.commitDestReg_o != RegZeroAlias)) begin
      rob.resets_o[rob.commitDestReg_o] = 1'b1;
    end
  end

  // operand read ports: stored value first, then same-cycle CDB bypass
  logic [MW-1:0] rd_tag   [2];
  logic [PW-1:0] rd_idx   [2];
  logic          rd_ready [2];
  logic [DW-1:0] rd_value [2];

  assign rd_tag[0] = rob.readTag1_i;
  assign rd_tag[1] = rob.readTag2_i;
  assign rd_idx[0] = PW'(rob.readTag1_i - TagOne);
  assign rd_idx[1] = PW'(rob.readTag2_i - TagOne);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_ready[p] = 1'b0;
      rd_value[p] = '0;
      if ((rd_tag[p] != '0) && (rd_tag[p] <= TagMax)) begin
        if (done_q[rd_idx[p]]) begin
          rd_ready[p] = 1'b1;
          rd_value[p] = value_q[rd_idx[p]];
        end else if (rob.cdb_valid_i && (rob.cdb_tag_i == rd_tag[p])) begin
          rd_ready[p] = 1'b1;
          rd_value[p] = rob.cdb_value_i;
        end
      end
    end
  end

  assign rob.readReady1_o = rd_ready[0];
  assign rob.readReady2_o = rd_ready[1];
  assign rob.readValue1_o = rd_value[0];
  assign rob.readValue2_o = rd_value[1];

  // control state: pointers, occupancy, valid/done flags
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (cdb_hit) begin
        done_q[cdb_idx] <= 1'b1;
      end
      if (do_commit) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_nxt;
      end
      if (do_alloc) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_nxt;
      end
      case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + TagOne;
        2'b01:   count_q <= count_q - TagOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // payload capture on allocate and on completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_alloc) begin
        regwrite_q[tail_q] <= rob.alloc_regWrite_i;
        dest_q[tail_q]     <= rob.alloc_destReg_i;
      end
      if (cdb_hit) begin
        value_q[cdb_idx] <= rob.cdb_value_i;
      end
    end
  end

endmodule
